// File: rtl/collatz_arbiter.sv
// Round-robin front end that time-shares one external Collatz iterator core
// among NREQ requesters and returns each job's step count tagged with its id.
module collatz_arbiter #(
   parameter int NREQ     = 4,
   parameter int ID_BITS  = 2,
   parameter int MAX_ITER = 65535
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NREQ-1:0]      req,
   input  logic [32*NREQ-1:0]   req_n,
   output logic [NREQ-1:0]      gnt,
   output logic                 resp_valid,
   output logic [ID_BITS-1:0]   resp_id,
   output logic [15:0]          resp_count,
   output logic                 resp_sat,
   output logic                 busy,
   output logic                 cgo,
   output logic [31:0]          cn,
   input  logic                 cdone,
   output logic [1:0]           dbg_state
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_RUN  = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   localparam logic [15:0]        C_CAP    = 16'(MAX_ITER);
   localparam logic [15:0]        C_CAP_M1 = 16'(MAX_ITER - 1);
   localparam logic [ID_BITS-1:0] C_ID_LAST = ID_BITS'(NREQ - 1);

   // Handshake: req[i]/slice i are held by the client until gnt[i] pulses;
   // resp_valid is a bare one-cycle pulse with no back-pressure.

   logic [1:0]          r_state;
   logic [ID_BITS-1:0]  r_ptr;
   logic [ID_BITS-1:0]  r_id;
   logic [31:0]         r_cn;
   logic [15:0]         r_count;
   logic [ID_BITS-1:0]  r_resp_id;
   logic [15:0]         r_resp_count;
   logic                r_resp_sat;

   logic                w_req_any;
   logic                w_hit;
   logic [ID_BITS-1:0]  w_win;
   logic [31:0]         w_win_slice;
   logic [ID_BITS-1:0]  w_ptr_next;
   logic [NREQ-1:0]     w_gnt;

   assign w_req_any = |req;

   // First pending requester at or after the pointer, wrapping to index 0.
   always_comb begin
      w_win = '0;
      w_hit = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (!w_hit && req[(int'(r_ptr) + k) % NREQ]) begin
            w_hit = 1'b1;
            w_win = ID_BITS'((int'(r_ptr) + k) % NREQ);
         end
      end
   end

   always_comb begin
      w_win_slice = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (ID_BITS'(k) == w_win) begin
            w_win_slice = req_n[32*k +: 32];
         end
      end
   end

   assign w_ptr_next = (w_win == C_ID_LAST) ? '0 : w_win + ID_BITS'(1);

   always_comb begin
      w_gnt = '0;
      if (r_state == S_LOAD) begin
         w_gnt[r_id] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_ptr        <= '0;
         r_id         <= '0;
         r_cn         <= '0;
         r_count      <= '0;
         r_resp_id    <= '0;
         r_resp_count <= '0;
         r_resp_sat   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req_any) begin
                  r_id    <= w_win;
                  r_cn    <= w_win_slice;
                  r_count <= '0;
                  r_ptr   <= w_ptr_next;
                  r_state <= S_LOAD;
               end
            end
            // cdone still reflects the core's previous job during LOAD.
            S_LOAD: begin
               r_state <= S_RUN;
            end
            S_RUN: begin
               if (cdone) begin
                  r_resp_id    <= r_id;
                  r_resp_count <= r_count;
                  r_resp_sat   <= 1'b0;
                  r_state      <= S_RESP;
               end else if (r_count == C_CAP_M1) begin
                  r_count      <= C_CAP;
                  r_resp_id    <= r_id;
                  r_resp_count <= C_CAP;
                  r_resp_sat   <= 1'b1;
                  r_state      <= S_RESP;
               end else begin
                  r_count <= r_count + 16'd1;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign gnt        = w_gnt;
   assign cgo        = (r_state == S_LOAD);
   assign cn         = r_cn;
   assign resp_valid = (r_state == S_RESP);
   assign resp_id    = r_resp_id;
   assign resp_count = r_resp_count;
   assign resp_sat   = r_resp_sat;
   assign busy       = (r_state != S_IDLE);
   assign dbg_state  = r_state;

endmodule
